// File: rtl/ffd_reg_share_arbiter.sv
// ffd_reg_share_arbiter
// Round-robin arbiter and load sequencer that shares one WIDTH-bit register
// (a bank of async-reset D flip-flops) between N_REQ requesters. The owner
// loads its din slice into Q on every edge where it still requests.
//
// Optional feature macro: HOLD_LIMIT_EN
//   defined   - an ownership tenure ends after MAX_HOLD loads (forced release)
//   undefined - the owner keeps the grant for as long as its req stays high
module ffd_reg_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     din,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           Q,
    output logic                       q_load
);

    localparam int OW = $clog2(N_REQ);

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("ffd_reg_share_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("ffd_reg_share_arbiter: MAX_HOLD must be >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t           state;
    logic [OW-1:0]    ptr;

`ifdef HOLD_LIMIT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    logic [HW-1:0]    hold_cnt;
`endif

    logic             sel_found;
    logic [OW-1:0]    sel_idx;
    logic [N_REQ-1:0] sel_onehot;
    logic [OW-1:0]    next_ptr;
    logic [WIDTH-1:0] owner_data;
    int               cand;

    // Round-robin pick: first set req bit searching ptr, ptr+1, ... cyclically.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path can hold a previous value and infer a latch.
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = OW'(cand);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            sel_onehot[i] = (int'(sel_idx) == i);
        end
    end

    // Pointer after a release and the current owner's data slice.
    always_comb begin
        next_ptr   = (int'(owner) == N_REQ - 1) ? '0 : owner + OW'(1);
        owner_data = din[int'(owner)*WIDTH +: WIDTH];
    end

    // Two-state ownership FSM with registered grant, status and shared register.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments only; Q is
        // cleared by the async reset together with the control state because
        // the shared register must read zero while Reset is high.
        if (Reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            Q        <= '0;
            q_load   <= 1'b0;
`ifdef HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            q_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        state    <= S_OWN;
                        gnt      <= sel_onehot;
                        owner    <= sel_idx;
                        busy     <= 1'b1;
`ifdef HOLD_LIMIT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                S_OWN: begin
                    if (req[owner]) begin
                        Q        <= owner_data;
                        q_load   <= 1'b1;
`ifdef HOLD_LIMIT_EN
                        hold_cnt <= hold_cnt + HW'(1);
                        // This load is load number MAX_HOLD: forced release.
                        if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                            state <= S_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            ptr   <= next_ptr;
                        end
`endif
                    end else begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffd_reg_share_arbiter.sv
// Self-checking bench for ffd_reg_share_arbiter. A behavioural ownership model
// is compared against the DUT after every clock edge and reset assertion;
// directed scenarios add literal expectations. Honors HOLD_LIMIT_EN.
module tb_ffd_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic             Clk   = 1'b0;
    logic             Reset = 1'b1;
    logic [N-1:0]     req   = '0;
    logic [W-1:0]     din_arr [N];
    logic [N*W-1:0]   din_bus;
    logic [N-1:0]     gnt;
    logic [1:0]       owner;
    logic             busy;
    logic [W-1:0]     Q;
    logic             q_load;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: who owns, whom to search from next, register.
    bit         m_own  = 1'b0;
    int         m_cur  = 0;
    int         m_ptr  = 0;
    int         m_last = 0;
    logic [7:0] m_q    = '0;
    bit         m_ql   = 1'b0;
`ifdef HOLD_LIMIT_EN
    int         m_nloads = 0;
`endif

    ffd_reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .din    (din_bus),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .Q      (Q),
        .q_load (q_load)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        din_bus = '0;
        for (int i = 0; i < N; i++) din_bus[i*W +: W] = din_arr[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 1'b0; m_cur = 0; m_ptr = 0; m_last = 0; m_q = '0; m_ql = 1'b0;
`ifdef HOLD_LIMIT_EN
        m_nloads = 0;
`endif
    endtask

    task automatic model_release();
        m_own = 1'b0;
        m_ptr = (m_cur + 1) % N;
    endtask

    // One clock edge of the ownership rules, using the inputs seen at the edge.
    task automatic model_step();
        m_ql = 1'b0;
        if (!m_own) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (req[idx]) begin
                    m_own = 1'b1; m_cur = idx; m_last = idx;
`ifdef HOLD_LIMIT_EN
                    m_nloads = 0;
`endif
                    break;
                end
            end
        end else if (req[m_cur]) begin
            m_q  = din_arr[m_cur];
            m_ql = 1'b1;
`ifdef HOLD_LIMIT_EN
            m_nloads++;
            if (m_nloads == MH) model_release();
`endif
        end else begin
            model_release();
        end
    endtask

    // Compare process: advance the model, then check every output 1 ns later.
    initial begin
        logic [N-1:0] eg;
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) model_reset();
            else       model_step();
            #1;
            eg = m_own ? (N'(1) << m_cur) : '0;
            check("model_gnt",    gnt,    eg);
            check("model_owner",  owner,  m_last);
            check("model_busy",   busy,   m_own);
            check("model_q",      Q,      m_q);
            check("model_q_load", q_load, m_ql);
        end
    end

    task automatic clk_edge();
        @(posedge Clk);
        #1;
    endtask

    // Assert reset 3 ns after an edge, hold across two edges, release at +1.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        clk_edge();
        clk_edge();
        Reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rr_seq [5];
        for (int i = 0; i < N; i++) din_arr[i] = 8'h11 * (i + 1);

        // Reset held with all requests active.
        req = 4'b1111;
        repeat (2) begin
            clk_edge();
            check("rst_q",      Q,      8'h00);
            check("rst_gnt",    gnt,    4'b0000);
            check("rst_busy",   busy,   1'b0);
            check("rst_owner",  owner,  2'd0);
            check("rst_q_load", q_load, 1'b0);
        end

        // Single requester.
        Reset = 1'b0; req = 4'b0010; din_arr[1] = 8'hA5;
        clk_edge();
        check("single_gnt",    gnt,    4'b0010);
        check("single_owner",  owner,  2'd1);
        check("single_noload", q_load, 1'b0);
        clk_edge();
        check("single_q",      Q,      8'hA5);
        check("single_q_load", q_load, 1'b1);
        req = 4'b0000;
        clk_edge();
        check("single_rel_gnt",   gnt,   4'b0000);
        check("single_rel_busy",  busy,  1'b0);
        check("single_rel_q",     Q,     8'hA5);
        check("single_rel_owner", owner, 2'd1);

`ifdef HOLD_LIMIT_EN
        // Hold limit: four loads then forced release and regrant.
        do_reset();
        req = 4'b0001;
        clk_edge();
        check("hold_gnt", gnt, 4'b0001);
        for (int j = 1; j <= 4; j++) begin
            din_arr[0] = 8'(j);
            clk_edge();
            check("hold_q",      Q,      32'(j));
            check("hold_q_load", q_load, 1'b1);
        end
        check("hold_rel_gnt", gnt, 4'b0000);
        din_arr[0] = 8'h05;
        clk_edge();
        check("hold_regnt", gnt, 4'b0001);
        check("hold_q4",    Q,   8'h04);
        clk_edge();
        check("hold_q5",    Q,   8'h05);

        // Round-robin with all requesters active.
        do_reset();
        req = 4'b1111;
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        for (int t = 0; t < 5; t++) begin
            clk_edge();
            check("rr_gnt", gnt, rr_seq[t]);
            repeat (4) clk_edge();
            check("rr_bubble", gnt, 4'b0000);
        end
`else
        // No limit: owner 2 keeps the grant while its request stays high.
        do_reset();
        req = 4'b0100;
        clk_edge();
        check("nolim_gnt0", gnt, 4'b0100);
        req = 4'b0101;
        for (int j = 0; j < 10; j++) begin
            din_arr[2] = 8'($urandom);
            clk_edge();
            check("nolim_gnt",    gnt,    4'b0100);
            check("nolim_q_load", q_load, 1'b1);
        end
        req = 4'b0001;
        clk_edge();
        check("nolim_bubble", gnt, 4'b0000);
        clk_edge();
        check("nolim_next",   gnt, 4'b0001);
`endif

        // Pointer wrap: release of requester 3 makes requester 0 first in line.
        do_reset();
        req = 4'b1000;
        clk_edge();
        check("wrap_gnt3", gnt, 4'b1000);
        req = 4'b0000;
        clk_edge();
        req = 4'b1001;
        clk_edge();
        check("wrap_gnt0", gnt, 4'b0001);

        // Async reset in the middle of an ownership.
        do_reset();
        req = 4'b0100; din_arr[2] = 8'h3C;
        clk_edge();
        clk_edge();
        check("arst_pre_gnt", gnt, 4'b0100);
        check("arst_pre_q",   Q,   8'h3C);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_q",    Q,    8'h00);
        check("arst_gnt",  gnt,  4'b0000);
        check("arst_busy", busy, 1'b0);
        req = 4'b0101;
        clk_edge();
        Reset = 1'b0;
        clk_edge();
        check("arst_first_gnt", gnt, 4'b0001);

        // Randomized traffic with sticky requests and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            for (int i = 0; i < N; i++) din_arr[i] = 8'($urandom);
            clk_edge();
            if (Reset) begin
                Reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                #2;
                Reset = 1'b1;
            end
        end
        Reset = 1'b0;
        clk_edge();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
